// File: rtl/main_mem_responder.sv
// main_mem_responder
//   Memory end of the cache line-fill interface. Accepts one line-sized read
//   or write at a time, waits a fixed LATENCY, then pulses mem_res_ready for
//   one cycle. Read data is returned on mem_res_data and held until the next
//   read completes.
//
// Ports
//   clk            clock, all state on posedge
//   rst            synchronous reset, active low
//   mem_req_valid  request present (held by requester until mem_res_ready)
//   mem_req_rw     0 = read line, 1 = write line
//   mem_req_addr   byte address, line index = addr[15:4] mod DEPTH_LINES
//   mem_req_data   write line, word 0 in bits [15:0]
//   mem_res_ready  one-cycle completion pulse
//   mem_res_data   last read line (held through writes / idle)
//   mem_busy       high whenever the FSM is not IDLE
//   req_count      completed-request counter, wraps at 16 bits
module main_mem_responder #(
  parameter int    LINE_WORDS  = 8,
  parameter int    LATENCY     = 4,     // 1..15
  parameter int    DEPTH_LINES = 4096,  // power of 2, >= 2
  parameter string INIT_FILE   = "",
  localparam int   LINE_W      = 16 * LINE_WORDS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_req_valid,
  input  logic              mem_req_rw,
  input  logic [15:0]       mem_req_addr,
  input  logic [LINE_W-1:0] mem_req_data,
  output logic              mem_res_ready,
  output logic [LINE_W-1:0] mem_res_data,
  output logic              mem_busy,
  output logic [15:0]       req_count
);

  localparam int IDX_W = $clog2(DEPTH_LINES);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              r_state;
  logic [3:0]          r_cnt;
  logic                r_rw;
  logic [IDX_W-1:0]    r_idx;
  logic [LINE_W-1:0]   r_data;
  logic                r_ready;
  logic [LINE_W-1:0]   r_rdata;
  logic                r_busy;
  logic [15:0]         r_count;
  logic [LINE_W-1:0]   r_mem [DEPTH_LINES];

  logic [IDX_W-1:0]    w_idx;
  logic                w_commit;
  logic                w_unused_lo;

  // Truncating cast gives the "mod DEPTH_LINES" aliasing for free.
  assign w_idx       = IDX_W'(mem_req_addr[15:4]);
  assign w_unused_lo = ^mem_req_addr[3:0];

  // Access happens on the BUSY edge where the countdown has reached zero.
  // Gated with rst so a reset landing on that edge abandons the write.
  assign w_commit = rst && (r_state == BUSY) && (r_cnt == 4'd0);

  // Backing array has no reset; contents survive rst.
  always_ff @(posedge clk) begin
    if (w_commit && r_rw)
      r_mem[r_idx] <= r_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_rw    <= 1'b0;
      r_idx   <= '0;
      r_data  <= '0;
      r_ready <= 1'b0;
      r_rdata <= '0;
      r_busy  <= 1'b0;
      r_count <= 16'd0;
    end else begin
      case (r_state)
        IDLE: begin
          r_ready <= 1'b0;
          if (mem_req_valid) begin
            r_rw    <= mem_req_rw;
            r_idx   <= w_idx;
            r_data  <= mem_req_data;
            r_cnt   <= CNT_INIT;
            r_busy  <= 1'b1;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          // Request inputs are deliberately not looked at here.
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            if (!r_rw)
              r_rdata <= r_mem[r_idx];
            r_ready <= 1'b1;
            r_count <= r_count + 16'd1;
            r_state <= DONE;
          end
        end
        DONE: begin
          // One dead cycle so a held valid is not re-captured immediately.
          r_ready <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_ready <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign mem_res_ready = r_ready;
  assign mem_res_data  = r_rdata;
  assign mem_busy      = r_busy;
  assign req_count     = r_count;

endmodule

// File: tb/tb_main_mem_responder.sv
module tb_main_mem_responder;

  localparam int LW = 128;

  logic          clk = 1'b0;
  logic          rst = 1'b0;

  // LATENCY=4 instance
  logic          v = 1'b0, rw = 1'b0;
  logic [15:0]   addr = '0;
  logic [LW-1:0] wd = '0;
  logic          ready, busy;
  logic [LW-1:0] rdata;
  logic [15:0]   cnt;

  // LATENCY=1 instance
  logic          v1 = 1'b0, rw1 = 1'b0;
  logic [15:0]   addr1 = '0;
  logic [LW-1:0] wd1 = '0;
  logic          ready1, busy1;
  logic [LW-1:0] rdata1;
  logic [15:0]   cnt1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  main_mem_responder #(.LINE_WORDS(8), .LATENCY(4), .DEPTH_LINES(4096), .INIT_FILE("")) dut (
    .clk(clk), .rst(rst),
    .mem_req_valid(v), .mem_req_rw(rw), .mem_req_addr(addr), .mem_req_data(wd),
    .mem_res_ready(ready), .mem_res_data(rdata), .mem_busy(busy), .req_count(cnt)
  );

  main_mem_responder #(.LINE_WORDS(8), .LATENCY(1), .DEPTH_LINES(4096), .INIT_FILE("")) dut1 (
    .clk(clk), .rst(rst),
    .mem_req_valid(v1), .mem_req_rw(rw1), .mem_req_addr(addr1), .mem_req_data(wd1),
    .mem_res_ready(ready1), .mem_res_data(rdata1), .mem_busy(busy1), .req_count(cnt1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request on the LATENCY=4 instance and stop on the ready cycle.
  // With mutate set, the request inputs are scrambled right after capture.
  task automatic req(input string tag, input logic irw, input logic [15:0] ia,
                     input logic [LW-1:0] id, input bit mutate);
    int k;
    v = 1'b1; rw = irw; addr = ia; wd = id;
    step();
    if (mutate) begin
      rw = ~irw; addr = 16'h0400; wd = {8{16'hDEAD}};
    end
    k = 0;
    while (!ready && k < 20) begin
      step();
      k++;
    end
    chk({tag, "_lat"}, LW'(k), LW'(4));
    v = 1'b0;
  endtask

  // DONE edge: ready drops and busy clears.
  task automatic finish(input string tag);
    step();
    chk({tag, "_rdy0"}, LW'(ready), LW'(0));
    chk({tag, "_busy0"}, LW'(busy), LW'(0));
  endtask

  localparam logic [LW-1:0] P0 = 128'h0007_0006_0005_0004_0003_0002_0001_0000;
  localparam logic [LW-1:0] PA = {8{16'hAAAA}};
  localparam logic [LW-1:0] P1 = {8{16'h1111}};
  localparam logic [LW-1:0] P2 = {8{16'h2222}};
  localparam logic [LW-1:0] P3 = {8{16'h3333}};
  localparam logic [LW-1:0] P5 = {8{16'h5555}};

  initial begin
    logic [19:0] mask;
    logic [8:0]  mask1;
    logic        seen;
    logic [15:0] c0;

    // Reset
    rst = 1'b0;
    step(); step();
    chk("rst_ready", LW'(ready), LW'(0));
    chk("rst_data",  rdata,      '0);
    chk("rst_busy",  LW'(busy),  LW'(0));
    chk("rst_cnt",   LW'(cnt),   LW'(0));
    rst = 1'b1;

    // Preload line 0x002, then read it back
    req("wr20", 1'b1, 16'h0020, P0, 1'b0);
    chk("wr20_data_held", rdata, '0);
    chk("wr20_cnt", LW'(cnt), LW'(1));
    finish("wr20");
    req("rd20", 1'b0, 16'h0020, '0, 1'b0);
    chk("rd20_data", rdata, P0);
    chk("rd20_cnt", LW'(cnt), LW'(2));
    chk("rd20_busy_at_ready", LW'(busy), LW'(1));
    finish("rd20");

    // Write then read, offset bits ignored
    req("wr1234", 1'b1, 16'h1234, PA, 1'b0);
    chk("wr1234_data_held", rdata, P0);
    finish("wr1234");
    req("rd1230", 1'b0, 16'h1230, '0, 1'b0);
    chk("rd1230_data", rdata, PA);
    finish("rd1230");
    req("rd123f", 1'b0, 16'h123F, '0, 1'b0);
    chk("rd123f_data", rdata, PA);
    finish("rd123f");

    // Known contents for 0x0400, then abort a write to it with reset
    req("wr400", 1'b1, 16'h0400, P1, 1'b0);
    finish("wr400");
    v = 1'b1; rw = 1'b1; addr = 16'h0400; wd = P5;
    step();                 // capture
    seen = ready;
    step();                 // first BUSY edge
    seen |= ready;
    rst = 1'b0;
    step();                 // second BUSY edge, reset wins
    seen |= ready;
    rst = 1'b1; v = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      seen |= ready;
    end
    chk("abort_no_ready", LW'(seen), LW'(0));
    chk("abort_cnt", LW'(cnt), LW'(0));
    chk("abort_busy", LW'(busy), LW'(0));
    req("rd400", 1'b0, 16'h0400, '0, 1'b0);
    chk("rd400_data", rdata, P1);
    chk("rd400_cnt", LW'(cnt), LW'(1));
    finish("rd400");

    // Inputs changed during BUSY must not matter
    req("mutrd", 1'b0, 16'h0020, '0, 1'b1);
    chk("mutrd_data", rdata, P0);
    finish("mutrd");
    req("mutwr", 1'b1, 16'h0600, P2, 1'b1);
    chk("mutwr_data_held", rdata, P0);
    finish("mutwr");
    req("rd600", 1'b0, 16'h0600, '0, 1'b0);
    chk("rd600_data", rdata, P2);
    finish("rd600");
    req("rd400b", 1'b0, 16'h0400, '0, 1'b0);
    chk("rd400b_data", rdata, P1);
    finish("rd400b");

    // Held valid: pulses at 4, 10, 16 after the first capture
    c0 = cnt;
    v = 1'b1; rw = 1'b0; addr = 16'h1230;
    mask = '0;
    for (int c = 0; c < 20; c++) begin
      step();
      mask[c] = ready;
    end
    chk("held_mask", LW'(mask), LW'(20'h10410));
    chk("held_cnt", LW'(cnt - c0), LW'(3));
    chk("held_data", rdata, PA);
    v = 1'b0;
    for (int i = 0; i < 8; i++) step();
    chk("held_tail_cnt", LW'(cnt - c0), LW'(4));

    // LATENCY=1 instance: write, then held back-to-back reads
    v1 = 1'b1; rw1 = 1'b1; addr1 = 16'h0050; wd1 = P3;
    step();
    step();
    chk("l1_wr_ready", LW'(ready1), LW'(1));
    step();
    rw1 = 1'b0; wd1 = '0;
    mask1 = '0;
    for (int c = 0; c < 9; c++) begin
      step();
      mask1[c] = ready1;
    end
    chk("l1_mask", LW'(mask1), LW'(9'h092));
    chk("l1_data", rdata1, P3);
    chk("l1_cnt", LW'(cnt1), LW'(4));
    v1 = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
